// File: rtl/stage_1_fetch_pkg.sv
// ----------------------------------------------------------------------------
// stage_1_fetch_pkg
// Shared definitions for the instruction-fetch stage: reset PC default, NOP
// encoding, fetch FSM state encoding and the watchdog counter width.
// ----------------------------------------------------------------------------
package stage_1_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam int          WDOG_W           = 8;

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_HOLD  = 2'b01,
        S_FAULT = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/stage_1_fetch_if.sv
// ----------------------------------------------------------------------------
// stage_1_fetch_if
// Instruction-memory request/response bus.
//   imem_req    fetch -> memory  request strobe (registered in the fetch stage)
//   imem_addr   fetch -> memory  word address of the request
//   imem_ready  memory -> fetch  response strobe, rdata valid in same cycle
//   imem_rdata  memory -> fetch  instruction word
// Modports: master (fetch stage side), slave (memory side).
// ----------------------------------------------------------------------------
interface stage_1_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/stage_1_fetch_watchdog.sv
// ----------------------------------------------------------------------------
// stage_1_fetch_watchdog
// Counts request cycles that go unanswered and flags the cycle in which the
// count reaches TIMEOUT_CYCLES.
// Ports:
//   clock      system clock
//   reset      asynchronous active-high reset, clears the count
//   clear_i    synchronous clear (new fetch starts)
//   inc_i      one unanswered request cycle
//   timeout_o  high in the cycle whose increment reaches TIMEOUT_CYCLES
// ----------------------------------------------------------------------------
module stage_1_fetch_watchdog
    import stage_1_fetch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic inc_i,
    output logic timeout_o
);

    // Count value from which one more increment reaches the limit.
    localparam logic [WDOG_W-1:0] LAST_CNT = WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [WDOG_W-1:0] cnt_q;
    logic [WDOG_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + WDOG_W'(1);
        end
    end

    assign timeout_o = inc_i && !clear_i && (cnt_q == LAST_CNT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stage_1_fetch.sv
// ----------------------------------------------------------------------------
// stage_1_fetch
// Instruction-fetch stage. Holds the architectural PC, fetches the word at
// pc over the imem bus, presents it to decode/execute until advance, then
// loads the next PC from pc_result. A hung memory access becomes a sticky
// fault (cleared only by reset).
// Ports:
//   clock, reset   clock and asynchronous active-high reset
//   advance        downstream consumed the instruction; take pc_result
//   pc_result      next PC from execute
//   imem           instruction memory bus (master side)
//   instr          captured instruction, NOP when not valid
//   instr_valid    instr/pc/pc_4 valid
//   pc, pc_4       PC of instr and pc + 4 (wraps modulo 2^32)
//   fetch_fault    sticky fault flag
// Build option: FETCH_ALIGN_CHECK_EN -- when defined, an advance to a
// misaligned pc_result faults instead of silently aligning the PC.
// ----------------------------------------------------------------------------
module stage_1_fetch
    import stage_1_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   advance,
    input  logic [31:0]            pc_result,
    stage_1_fetch_if.master        imem,
    output logic [31:0]            instr,
    output logic                   instr_valid,
    output logic [31:0]            pc,
    output logic [31:0]            pc_4,
    output logic                   fetch_fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         valid_q, valid_d;
    logic         req_q, req_d;
    logic         fault_q, fault_d;
    logic         wd_clear, wd_inc, wd_timeout;

    stage_1_fetch_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (wd_clear),
        .inc_i     (wd_inc),
        .timeout_o (wd_timeout)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        req_d    = req_q;
        fault_d  = fault_q;
        wd_clear = 1'b0;
        wd_inc   = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                if (!req_q) begin
                    // First cycle in S_FETCH: raise the request.
                    req_d = 1'b1;
                end else if (imem.imem_ready) begin
                    // Ready wins over a timeout reached in the same cycle.
                    instr_d = imem.imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = S_HOLD;
                end else begin
                    wd_inc = 1'b1;
                    if (wd_timeout) begin
                        req_d   = 1'b0;
                        fault_d = 1'b1;
                        state_d = S_FAULT;
                    end
                end
            end

            S_HOLD: begin
                if (advance) begin
                    valid_d  = 1'b0;
                    instr_d  = NOP_INSTR;
                    wd_clear = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
                    pc_d = pc_result;
                    if (pc_result[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        req_d   = 1'b0;
                        state_d = S_FAULT;
                    end else begin
                        req_d   = 1'b1;
                        state_d = S_FETCH;
                    end
`else
                    pc_d    = pc_result & 32'hFFFF_FFFC;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
`endif
                end
            end

            S_FAULT: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
                fault_d = 1'b1;
            end

            default: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
                fault_d = 1'b1;
                state_d = S_FAULT;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            fault_q <= fault_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = valid_q;
    assign pc             = pc_q;
    assign pc_4           = pc_q + 32'd4;
    assign fetch_fault    = fault_q;

endmodule

// File: tb/tb_stage_1_fetch.sv
module tb_stage_1_fetch;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam int          TMO    = 16;

    logic        clock     = 1'b0;
    logic        reset     = 1'b0;
    logic        advance   = 1'b0;
    logic [31:0] pc_result = 32'h0;
    logic [31:0] instr, pc, pc_4;
    logic        instr_valid, fetch_fault;

    stage_1_fetch_if imem_bus ();

    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] sb_q[$];   // {instr, pc} expected per completed fetch
    logic [63:0] exp_e;

    stage_1_fetch #(
        .RESET_PC       (RST_PC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .advance     (advance),
        .pc_result   (pc_result),
        .imem        (imem_bus),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_4        (pc_4),
        .fetch_fault (fetch_fault)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        advance = 1'b0;
        imem_bus.imem_ready = 1'b0;
        sb_q.delete();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Memory responder: waits (bounded) for a request, delays, answers once
    // and records the expected capture in the scoreboard.
    task automatic serve(input logic [31:0] data, input logic [31:0] exp_pc,
                         input int delay, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (imem_bus.imem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (imem_bus.imem_req !== 1'b1) return;
        repeat (delay) step();
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = data;
        sb_q.push_back({data, exp_pc});
        step();
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = $urandom;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        tests_run++; if (pc !== RST_PC) begin tests_failed++; $display("FAIL rst_pc: got %h expected %h", pc, RST_PC); end
        tests_run++; if ({imem_bus.imem_req, instr_valid, fetch_fault} !== 3'b000) begin tests_failed++; $display("FAIL rst_flags: got req/valid/fault=%b expected 000", {imem_bus.imem_req, instr_valid, fetch_fault}); end
        tests_run++; if (instr !== 32'h0) begin tests_failed++; $display("FAIL rst_instr: got %h expected 00000000", instr); end
        tests_run++; if (pc_4 !== 32'h0040_0004) begin tests_failed++; $display("FAIL rst_pc4: got %h expected 00400004", pc_4); end
        step();
        step();
        reset = 1'b0;
        tests_run++; if (imem_bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL rst_req_release: got %b expected 0", imem_bus.imem_req); end
        step();
        tests_run++; if (imem_bus.imem_req !== 1'b1) begin tests_failed++; $display("FAIL req_first_cycle: got %b expected 1", imem_bus.imem_req); end
    endtask

    task automatic test_basic_fetch();
        tests_run++; if (imem_bus.imem_addr !== RST_PC) begin tests_failed++; $display("FAIL basic_addr: got %h expected %h", imem_bus.imem_addr, RST_PC); end
        step();
        step();
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = 32'h2008_0005;
        sb_q.push_back({32'h2008_0005, RST_PC});
        step();
        imem_bus.imem_ready = 1'b0;
        tests_run++;
        if (instr_valid !== 1'b1 || sb_q.size() == 0) begin
            tests_failed++; $display("FAIL basic_valid: got valid=%b queued=%0d expected valid=1 queued>0", instr_valid, sb_q.size());
        end else begin
            exp_e = sb_q.pop_front();
            if ({instr, pc} !== exp_e) begin tests_failed++; $display("FAIL basic_capture: got %h expected %h", {instr, pc}, exp_e); end
        end
        tests_run++; if (pc_4 !== 32'h0040_0004 || imem_bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL basic_pc4_req: got pc_4=%h req=%b expected 00400004 0", pc_4, imem_bus.imem_req); end
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = 32'hBAD0_BAD0;
        step();
        step();
        imem_bus.imem_ready = 1'b0;
        tests_run++; if ({instr_valid, instr} !== {1'b1, 32'h2008_0005}) begin tests_failed++; $display("FAIL hold_stable: got %b/%h expected 1/20080005", instr_valid, instr); end
    endtask

    task automatic test_advance();
        bit ok;
        advance = 1'b1;
        pc_result = 32'h0040_0020;
        step();
        advance = 1'b0;
        tests_run++; if (pc !== 32'h0040_0020) begin tests_failed++; $display("FAIL adv_pc: got %h expected 00400020", pc); end
        tests_run++; if ({instr_valid, imem_bus.imem_req} !== 2'b01 || instr !== 32'h0) begin tests_failed++; $display("FAIL adv_flags: got valid/req=%b instr=%h expected 01 00000000", {instr_valid, imem_bus.imem_req}, instr); end
        serve(32'h0123_4567, 32'h0040_0020, 0, ok);
        tests_run++;
        if (!ok || instr_valid !== 1'b1 || sb_q.size() == 0) begin
            tests_failed++; $display("FAIL adv_fetch: got ok=%0d valid=%b expected ok=1 valid=1", ok, instr_valid);
        end else begin
            exp_e = sb_q.pop_front();
            if ({instr, pc} !== exp_e) begin tests_failed++; $display("FAIL adv_capture: got %h expected %h", {instr, pc}, exp_e); end
        end
    endtask

    task automatic test_advance_ignored();
        bit ok;
        advance = 1'b1;
        pc_result = 32'h0040_0040;
        step();
        pc_result = 32'h1234_5678;
        step();
        advance = 1'b0;
        tests_run++; if (pc !== 32'h0040_0040 || imem_bus.imem_req !== 1'b1) begin tests_failed++; $display("FAIL ign_pc: got pc=%h req=%b expected 00400040 1", pc, imem_bus.imem_req); end
        serve(32'hCAFE_0001, 32'h0040_0040, 1, ok);
        tests_run++;
        if (!ok || instr_valid !== 1'b1 || sb_q.size() == 0) begin
            tests_failed++; $display("FAIL ign_fetch: got ok=%0d valid=%b expected ok=1 valid=1", ok, instr_valid);
        end else begin
            exp_e = sb_q.pop_front();
            if ({instr, pc} !== exp_e) begin tests_failed++; $display("FAIL ign_capture: got %h expected %h", {instr, pc}, exp_e); end
        end
    endtask

    task automatic test_pc_wrap();
        bit ok;
        advance = 1'b1;
        pc_result = 32'hFFFF_FFFC;
        step();
        advance = 1'b0;
        tests_run++; if (pc_4 !== 32'h0000_0000 || pc !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_pc4: got pc=%h pc_4=%h expected fffffffc 00000000", pc, pc_4); end
        serve(32'h0000_0013, 32'hFFFF_FFFC, 0, ok);
        tests_run++;
        if (!ok || instr_valid !== 1'b1 || sb_q.size() == 0) begin
            tests_failed++; $display("FAIL wrap_fetch: got ok=%0d valid=%b expected ok=1 valid=1", ok, instr_valid);
        end else begin
            exp_e = sb_q.pop_front();
            if ({instr, pc} !== exp_e) begin tests_failed++; $display("FAIL wrap_capture: got %h expected %h", {instr, pc}, exp_e); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [31:0] tgt, data;
        for (int i = 0; i < 6; i++) begin
            tgt  = 32'h0000_1000 + 32'(i * 8);
            data = $urandom;
            advance = 1'b1;
            pc_result = tgt;
            step();
            advance = 1'b0;
            serve(data, tgt, int'($urandom_range(0, 4)), ok);
            tests_run++;
            if (!ok || instr_valid !== 1'b1 || sb_q.size() == 0) begin
                tests_failed++; $display("FAIL b2b_fetch[%0d]: got ok=%0d valid=%b expected ok=1 valid=1", i, ok, instr_valid);
            end else begin
                exp_e = sb_q.pop_front();
                if ({instr, pc} !== exp_e) begin tests_failed++; $display("FAIL b2b_capture[%0d]: got %h expected %h", i, {instr, pc}, exp_e); end
            end
        end
    endtask

    task automatic test_align();
        advance = 1'b1;
        pc_result = 32'h0040_0022;
        step();
        advance = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        tests_run++; if (fetch_fault !== 1'b1 || imem_bus.imem_req !== 1'b0 || pc !== 32'h0040_0022) begin tests_failed++; $display("FAIL align_fault: got fault=%b req=%b pc=%h expected 1 0 00400022", fetch_fault, imem_bus.imem_req, pc); end
        step();
        step();
        tests_run++; if (imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0) begin tests_failed++; $display("FAIL align_noreq: got req=%b valid=%b expected 0 0", imem_bus.imem_req, instr_valid); end
`else
        begin
            bit ok;
            tests_run++; if (pc !== 32'h0040_0020 || imem_bus.imem_req !== 1'b1 || fetch_fault !== 1'b0) begin tests_failed++; $display("FAIL align_force: got pc=%h req=%b fault=%b expected 00400020 1 0", pc, imem_bus.imem_req, fetch_fault); end
            serve(32'h00A0_0B0C, 32'h0040_0020, 0, ok);
            tests_run++;
            if (!ok || instr_valid !== 1'b1 || sb_q.size() == 0) begin
                tests_failed++; $display("FAIL align_fetch: got ok=%0d valid=%b expected ok=1 valid=1", ok, instr_valid);
            end else begin
                exp_e = sb_q.pop_front();
                if ({instr, pc} !== exp_e) begin tests_failed++; $display("FAIL align_capture: got %h expected %h", {instr, pc}, exp_e); end
            end
        end
`endif
    endtask

    task automatic test_timeout();
        do_reset();
        step();
        repeat (TMO - 1) step();
        tests_run++; if (imem_bus.imem_req !== 1'b1 || fetch_fault !== 1'b0) begin tests_failed++; $display("FAIL tmo_early: got req=%b fault=%b expected 1 0", imem_bus.imem_req, fetch_fault); end
        step();
        tests_run++; if ({fetch_fault, imem_bus.imem_req, instr_valid} !== 3'b100) begin tests_failed++; $display("FAIL tmo_fault: got fault/req/valid=%b expected 100", {fetch_fault, imem_bus.imem_req, instr_valid}); end
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = 32'h1111_2222;
        advance = 1'b1;
        pc_result = 32'h0000_0100;
        repeat (3) step();
        imem_bus.imem_ready = 1'b0;
        advance = 1'b0;
        tests_run++; if ({fetch_fault, imem_bus.imem_req, instr_valid} !== 3'b100 || pc !== RST_PC) begin tests_failed++; $display("FAIL tmo_sticky: got fault/req/valid=%b pc=%h expected 100 %h", {fetch_fault, imem_bus.imem_req, instr_valid}, pc, RST_PC); end
        #2 reset = 1'b1;
        #1;
        tests_run++; if (fetch_fault !== 1'b0 || pc !== RST_PC) begin tests_failed++; $display("FAIL tmo_reset: got fault=%b pc=%h expected 0 %h", fetch_fault, pc, RST_PC); end
        step();
        reset = 1'b0;
    endtask

    task automatic test_timeout_edge();
        do_reset();
        step();
        repeat (TMO - 1) step();
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = 32'h5A5A_0F0F;
        sb_q.push_back({32'h5A5A_0F0F, RST_PC});
        step();
        imem_bus.imem_ready = 1'b0;
        tests_run++;
        if (instr_valid !== 1'b1 || fetch_fault !== 1'b0 || sb_q.size() == 0) begin
            tests_failed++; $display("FAIL edge_success: got valid=%b fault=%b expected 1 0", instr_valid, fetch_fault);
        end else begin
            exp_e = sb_q.pop_front();
            if ({instr, pc} !== exp_e) begin tests_failed++; $display("FAIL edge_capture: got %h expected %h", {instr, pc}, exp_e); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        step();
        step();
        #2 reset = 1'b1;
        #1;
        tests_run++; if (imem_bus.imem_req !== 1'b0 || pc !== RST_PC || instr_valid !== 1'b0) begin tests_failed++; $display("FAIL midf_async: got req=%b pc=%h valid=%b expected 0 %h 0", imem_bus.imem_req, pc, instr_valid, RST_PC); end
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        reset = 1'b0;
        step();
        imem_bus.imem_ready = 1'b0;
        tests_run++; if (instr_valid !== 1'b0 || instr !== 32'h0 || imem_bus.imem_req !== 1'b1) begin tests_failed++; $display("FAIL midf_stale: got valid=%b instr=%h req=%b expected 0 00000000 1", instr_valid, instr, imem_bus.imem_req); end
        serve(32'h7777_0001, RST_PC, 0, ok);
        tests_run++;
        if (!ok || instr_valid !== 1'b1 || sb_q.size() == 0) begin
            tests_failed++; $display("FAIL midf_refetch: got ok=%0d valid=%b expected ok=1 valid=1", ok, instr_valid);
        end else begin
            exp_e = sb_q.pop_front();
            if ({instr, pc} !== exp_e) begin tests_failed++; $display("FAIL midf_capture: got %h expected %h", {instr, pc}, exp_e); end
        end
        #2 reset = 1'b1;
        #1;
        tests_run++; if (instr_valid !== 1'b0 || instr !== 32'h0 || pc !== RST_PC || imem_bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL midh_async: got valid=%b instr=%h pc=%h req=%b expected 0 00000000 %h 0", instr_valid, instr, pc, imem_bus.imem_req, RST_PC); end
        step();
        reset = 1'b0;
        step();
        tests_run++; if (imem_bus.imem_req !== 1'b1 || instr_valid !== 1'b0) begin tests_failed++; $display("FAIL midh_restart: got req=%b valid=%b expected 1 0", imem_bus.imem_req, instr_valid); end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got simulation still running expected finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        test_reset();
        test_basic_fetch();
        test_advance();
        test_advance_ignored();
        test_pc_wrap();
        test_back_to_back();
        test_align();
        test_timeout();
        test_timeout_edge();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/stage_1_fetch.md
Name: stage_1_fetch

Overview:
- Instruction-fetch stage of the CPU. Holds the architectural PC and fetches the instruction word from an external instruction memory over a req/ready handshake.
- Presents `instr`, `pc` and `pc_4` to decode/execute.
- On `advance`, loads the next PC from the execute stage's `pc_result` and starts the next fetch.
- A watchdog counter converts a hung memory access into a sticky fault.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, maximum cycles `imem_req` may stay high without `imem_ready` before a fault is raised; legal range 1..255.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- advance  input  1  downstream has consumed the current instruction; take `pc_result`.
- pc_result  input  32  next PC computed by the execute stage.
- imem_req  output  1  instruction memory request, registered.
- imem_addr  output  32  word address of the request; equals `pc`.
- imem_ready  input  1  memory response strobe; `imem_rdata` is valid in the same cycle.
- imem_rdata  input  32  instruction word.
- instr  output  32  captured instruction; NOP (32'h0) when not valid.
- instr_valid  output  1  `instr`/`pc`/`pc_4` are valid for downstream.
- pc  output  32  PC of `instr`.
- pc_4  output  32  `pc + 4`, modulo 2^32.
- fetch_fault  output  1  sticky fault flag; cleared only by reset.

Behaviour:
- Reset (asynchronous, dominates every other input):
  - `pc` = RESET_PC, state = S_FETCH, `imem_req` = 0, `instr` = 0, `instr_valid` = 0, `fetch_fault` = 0, timeout counter = 0.
  - Reset asserted mid-fetch abandons the request; a late `imem_ready` is ignored.
- States: S_FETCH, S_HOLD, S_FAULT. The encoding is a package constant.
- S_FETCH:
  - `imem_req` is registered high from the first cycle after reset deassertion, and from the cycle after entry into S_FETCH.
  - `imem_addr` = `pc`.
  - On a cycle with `imem_req` = 1 and `imem_ready` = 1: capture `imem_rdata` into `instr`, set `instr_valid` = 1 and `imem_req` = 0 on the next edge, then go to S_HOLD.
  - Latency: `imem_ready` sampled at edge N gives `instr_valid` high after edge N.
  - `imem_ready` while `imem_req` = 0 is ignored.
  - The counter increments on each `imem_req` = 1 cycle without ready. When it reaches TIMEOUT_CYCLES: go to S_FAULT, drop `imem_req`, set `fetch_fault` = 1.
  - Ready arriving in the same cycle the counter reaches TIMEOUT_CYCLES counts as success.
- S_HOLD:
  - `instr_valid` stays 1 and all outputs are held stable.
  - On `advance` = 1: `pc` <= `pc_result`, `instr_valid` <= 0, `instr` <= 0, counter <= 0, go to S_FETCH. `imem_req` rises on that same edge.
- `advance` outside S_HOLD is ignored; `pc` never changes except on reset or an accepted advance.
- S_FAULT:
  - Terminal until reset. `imem_req` = 0, `instr_valid` = 0, `fetch_fault` = 1.
- `pc_4` is combinational `pc + 4`. 32'hFFFF_FFFC gives 32'h0000_0000; no carry-out is kept.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - An accepted advance with `pc_result[1:0]` != 2'b00 loads `pc` and goes directly to S_FAULT with `fetch_fault` = 1.
  - No memory request is issued.
- Undefined:
  - No check is made; `pc_result[1:0]` is forced to 2'b00 when loaded into `pc`.

Decomposition:
- Shared package cpu_defs:
  - RESET_PC default value.
  - NOP_INSTR = 32'h0.
  - Fetch state typedef/localparams S_FETCH/S_HOLD/S_FAULT.
  - Counter width localparam = 8.
- One natural sub-module: fetch_watchdog, containing the counter, clear, increment-enable and a `timeout` pulse output. Everything else stays in stage_1_fetch.

Test Plan:
- Reset then `imem_ready` high on the 3rd request cycle with `imem_rdata` = 32'h2008_0005 -> `imem_addr` = 32'h0040_0000; next cycle `instr` = 32'h2008_0005, `instr_valid` = 1, `pc_4` = 32'h0040_0004.
- In S_HOLD, `advance` with `pc_result` = 32'h0040_0020 -> next cycle `pc` = 32'h0040_0020, `instr_valid` = 0, `imem_req` = 1.
- `advance` pulsed during S_FETCH with `pc_result` = 32'h1234_5678 -> `pc` unchanged; fetch completes normally.
- `imem_ready` held low for 16 request cycles -> `fetch_fault` = 1, `imem_req` = 0, stays so until reset; reset restores `pc` = 32'h0040_0000.
- Assert reset in the middle of S_FETCH and S_HOLD -> outputs reach their reset values immediately (asynchronously); a stale `imem_ready` afterward captures nothing.
- With FETCH_ALIGN_CHECK_EN: advance to 32'h0040_0022 -> `fetch_fault` = 1, no `imem_req`. Without the macro -> `pc` = 32'h0040_0020 and fetch proceeds.
